half_adder_core: RTL and testbench
==================================

# half_adder_core

Registered, handshaked bank of independent half-adder lanes. Each lane produces sum = a XOR b and carry = a AND b. The block sits as a leaf datapath stage behind the verification interface bundle (a, b in; s, c out). A single output register with valid/ready flow control and optional operation counters make it usable as a pipelined stage.

## Interface
- WIDTH, 1, number of independent half-adder lanes (≥1)
- CNT_W, 16, width of statistics counters (≥2)

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair a/b presented
- in_ready  output  1  stage can accept operands this cycle
- a  input  WIDTH  operand A, one bit per lane
- b  input  WIDTH  operand B, one bit per lane
- out_valid  output  1  s/c hold a valid result
- out_ready  input  1  downstream accepts result this cycle
- s  output  WIDTH  registered sum, lane i = a[i] ^ b[i]
- c  output  WIDTH  registered carry, lane i = a[i] & b[i]
- carry_any  output  1  registered OR-reduction of c
- cnt_clr  input  1  synchronous clear of statistics counters
- op_count  output  CNT_W  accepted operand transfers (saturating)
- carry_count  output  CNT_W  accepted transfers with any lane carry (saturating)

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational; full throughput, one result in flight).
- On input transfer: s <= a ^ b, c <= a & b, carry_any <= |(a & b), out_valid <= 1.
- On output transfer without simultaneous input transfer: out_valid <= 0; s/c/carry_any hold last values.
- While out_valid=1 and out_ready=0: s, c, carry_any, out_valid stable; in_ready=0, inputs ignored.
- Lanes fully independent; no carry propagation between lanes.
- op_count += 1 per input transfer; carry_count += 1 per input transfer with |(a & b) = 1; both saturate at 2^CNT_W-1 (no wrap).
- cnt_clr=1: both counters <= 0 that cycle; clear has priority over a simultaneous increment (that transfer not counted).
- Reset values: out_valid=0, s=0, c=0, carry_any=0, op_count=0, carry_count=0; in_ready=1 during and after reset.
- Reset asserted mid-operation: pending result discarded immediately (out_valid drops asynchronously); no partial state survives.

## Timing
- Latency: exactly 1 clk from input transfer to out_valid=1 with result.
- Throughput: one transfer per cycle when out_ready held high.
- No combinational path from a/b to any output; only out_ready → in_ready is combinational.
- rst_n assertion asynchronous; deassertion sampled at clk (synchronized externally).
- Counter outputs reflect transfers completed up to the previous edge.

## Configuration
- HALF_ADDER_STATS_EN defined: op_count/carry_count counters and cnt_clr logic implemented as above.
- Not defined: counters not instantiated; op_count and carry_count tied to 0; cnt_clr ignored. Datapath and handshake unchanged.

## Test plan
- WIDTH=1, out_ready=1, drive (a,b) = 00,01,10,11 on consecutive cycles → one cycle later s,c = 0/0, 1/0, 1/0, 0/1; carry_any=1 only for 11.
- WIDTH=4, a=4'b1011, b=4'b0110 → s=4'b1101, c=4'b0010, carry_any=1 after one cycle.
- Backpressure: result valid, out_ready=0 for 3 cycles with changing a/b → in_ready=0, s/c unchanged; raise out_ready → next operand accepted same cycle.
- Reset mid-flight: out_valid=1, pull rst_n low between edges → out_valid, s, c, counters 0 immediately; in_ready=1.
- Counters (STATS_EN, CNT_W=2): 5 transfers of a=b=all-ones → op_count=carry_count=3 (saturated); cnt_clr with simultaneous transfer → both 0.
- Without HALF_ADDER_STATS_EN: 10 transfers → op_count=carry_count=0, datapath results correct.

Source files
------------

// File: rtl/half_adder_core.sv
// half_adder_core: registered, valid/ready handshaked bank of independent
// half-adder lanes (s = a ^ b, c = a & b) with optional transfer counters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b: one bit per lane)
//   out_valid/out_ready result handshake (s, c, carry_any)
//   cnt_clr             synchronous clear of the statistics counters
//   op_count            accepted operand transfers (saturating)
//   carry_count         accepted transfers with any lane carry (saturating)
//
// Build option: define HALF_ADDER_STATS_EN to implement the counters;
// otherwise op_count/carry_count read 0 and cnt_clr is ignored.

module half_adder_core #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             carry_any,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] carry_count
);

    logic             in_xfer;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] carry_next;
    logic             carry_any_next;

    // Single result slot: accept when empty or when it drains this cycle.
    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;

    assign sum_next       = a ^ b;
    assign carry_next     = a & b;
    assign carry_any_next = |carry_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            c         <= '0;
            carry_any <= 1'b0;
        end else begin
            if (in_xfer) begin
                out_valid <= 1'b1;
                s         <= sum_next;
                c         <= carry_next;
                carry_any <= carry_any_next;
            end else if (out_ready) begin
                // Result drained with nothing behind it; data holds.
                out_valid <= 1'b0;
            end
        end
    end

`ifdef HALF_ADDER_STATS_EN

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] op_q;
    logic [CNT_W-1:0] carry_q;

    // Clear wins over a same-cycle transfer; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            carry_q <= '0;
        end else if (cnt_clr) begin
            op_q    <= '0;
            carry_q <= '0;
        end else if (in_xfer) begin
            if (op_q != CNT_MAX) begin
                op_q <= op_q + 1'b1;
            end
            if (carry_any_next && (carry_q != CNT_MAX)) begin
                carry_q <= carry_q + 1'b1;
            end
        end
    end

    assign op_count    = op_q;
    assign carry_count = carry_q;

`else

    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign op_count       = '0;
    assign carry_count    = '0;

`endif

    // A stalled result must not change until it is taken.
    property p_hold_on_stall;
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(s) && $stable(c) && $stable(carry_any));
    endproperty

    a_hold_on_stall : assert property (p_hold_on_stall);

    // The flag is always the reduction of the registered carries.
    property p_carry_any;
        @(posedge clk) disable iff (!rst_n)
        carry_any == (|c);
    endproperty

    a_carry_any : assert property (p_carry_any);

endmodule

// File: tb/tb_half_adder_core.sv
// tb_half_adder_core: directed vectors for half_adder_core (WIDTH=4,
// CNT_W=2) with a result scoreboard drained by an independent monitor.

module tb_half_adder_core;

    localparam int W = 4;
    localparam int CW = 2;

`ifdef HALF_ADDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic          carry_any;
    logic          cnt_clr;
    logic [CW-1:0] op_count;
    logic [CW-1:0] carry_count;

    half_adder_core #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s          (s),
        .c          (c),
        .carry_any  (carry_any),
        .cnt_clr    (cnt_clr),
        .op_count   (op_count),
        .carry_count(carry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {s, c, carry_any} per accepted operand pair.
    logic [2*W:0] sb[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every drained result is compared with the oldest expectation.
    initial begin
        logic [2*W:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", {s, c, carry_any}, 32'hdead);
                end else begin
                    e = sb.pop_front();
                    check("result", {23'd0, s, c, carry_any}, {23'd0, e});
                end
            end
        end
    end

    // Present one operand pair; leaves in_valid high for back-to-back use.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] es, input logic [W-1:0] ec,
                        input logic eca);
        int n;
        n = 0;
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back({es, ec, eca});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sc", {23'd0, s, c, carry_any}, 32'd0);
        check("rst_counts", {28'd0, op_count, carry_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Every lane sees 00, 01, 10, 11 on consecutive cycles.
        send(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        send(4'b0000, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        send(4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b0);
        send(4'b1111, 4'b1111, 4'b0000, 4'b1111, 1'b1);
        idle(2);
        check("cnt_op_sat", {30'd0, op_count}, STATS ? 32'd3 : 32'd0);
        check("cnt_carry_1", {30'd0, carry_count}, STATS ? 32'd1 : 32'd0);

        // Mixed lanes; no carry crosses between lanes.
        send(4'b1011, 4'b0110, 4'b1101, 4'b0010, 1'b1);
        send(4'b1010, 4'b0101, 4'b1111, 4'b0000, 1'b0);
        send(4'b1100, 4'b1010, 4'b0110, 4'b1000, 1'b1);
        send(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
        idle(2);

        // Backpressure: stalled result holds while inputs keep changing.
        out_ready = 1'b0;
        send(4'b1011, 4'b0110, 4'b1101, 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = 4'(i + 5);
            b = 4'(i * 3 + 1);
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", {23'd0, out_valid, s, c}, {23'd0, 9'b1_1101_0010});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        send(4'b0110, 4'b0011, 4'b0101, 4'b0010, 1'b1);
        idle(2);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_hold_s", {28'd0, s}, 32'b0101);

        // Reset with a stalled result in flight.
        out_ready = 1'b0;
        send(4'b1111, 4'b1111, 4'b0000, 4'b1111, 1'b1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sc", {23'd0, s, c, carry_any}, 32'd0);
        check("mid_rst_counts", {28'd0, op_count, carry_count}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Counter saturation, clear priority, restart.
        for (int i = 0; i < 5; i++) begin
            send(4'b1111, 4'b1111, 4'b0000, 4'b1111, 1'b1);
        end
        idle(1);
        check("sat_op", {30'd0, op_count}, STATS ? 32'd3 : 32'd0);
        check("sat_carry", {30'd0, carry_count}, STATS ? 32'd3 : 32'd0);
        cnt_clr = 1'b1;
        send(4'b0011, 4'b0001, 4'b0010, 4'b0001, 1'b1);
        cnt_clr = 1'b0;
        idle(1);
        check("clr_op", {30'd0, op_count}, 32'd0);
        check("clr_carry", {30'd0, carry_count}, 32'd0);
        send(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1);
        send(4'b0100, 4'b0010, 4'b0110, 4'b0000, 1'b0);
        idle(1);
        check("post_clr_op", {30'd0, op_count}, STATS ? 32'd2 : 32'd0);
        check("post_clr_carry", {30'd0, carry_count}, STATS ? 32'd1 : 32'd0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
